// File: rtl/la_rrarbiter_pkg.sv
// ---------------------------------------------------------------------------
// la_rrarbiter_pkg
// Purpose : shared types and helpers for the round-robin arbiter slice.
// Contents:
//   arb_state_e      - arbiter FSM state (idle / owned)
//   owner_width(n)   - width of the owner index and priority pointer,
//                      never narrower than one bit
// ---------------------------------------------------------------------------
package la_rrarbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/la_rrpick.sv
// ---------------------------------------------------------------------------
// la_rrpick
// Purpose : combinational rotating-priority picker. Finds the first set
//           request bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
// Ports   :
//   req    in  [N-1:0]  request vector (already masked by the caller)
//   ptr    in  [W-1:0]  index of the highest-priority requester
//   onehot out [N-1:0]  one-hot winner, zero when nothing requests
//   index  out [W-1:0]  binary index of the winner
//   valid  out          high when any request bit is set
// ---------------------------------------------------------------------------
module la_rrpick
    import la_rrarbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int W = owner_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] index,
    output logic         valid
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    int             first;
    int             sum;

    // Rotating the doubled vector right by ptr puts requester ptr at bit 0,
    // so a plain lowest-set-bit search follows the round-robin order.
    assign doubled = {req, req};
    assign rotated = N'(doubled >> ptr);
    assign valid   = |req;

    always_comb begin
        first = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                first = i;
            end
        end
        // Undo the rotation: winner = (ptr + first) mod N, with both terms < N.
        sum = int'(ptr) + first;
        if (sum >= N) begin
            sum = sum - N;
        end
        index  = W'(sum);
        onehot = valid ? (N'(1) << index) : '0;
    end

endmodule

// File: rtl/la_rrarbiter.sv
// ---------------------------------------------------------------------------
// la_rrarbiter
// Purpose : round-robin arbiter with grant locking. The winner keeps the
//           grant until it pulses done or drops its request; ownership then
//           passes to the next requester in rotating priority order, on the
//           same edge when another request is pending.
// Ports   :
//   clk    in          rising-edge clock
//   nreset in          asynchronous active-low reset
//   req    in  [N-1:0] level-sensitive request vector
//   done   in          single-cycle "owner finished" pulse, ignored when idle
//   grant  out [N-1:0] registered one-hot grant, zero when idle
//   busy   out         registered, high while a grant is held
//   owner  out [W-1:0] registered index of the current (or last) owner
// ---------------------------------------------------------------------------
module la_rrarbiter
    import la_rrarbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter     PROP = "DEFAULT",
    localparam int W   = owner_width(N)
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic [W-1:0] owner
);

    // The property string only steers implementation choices elsewhere; the
    // behavioural model here does not depend on it.
    localparam bit unused_prop = (PROP == "DEFAULT");

    arb_state_e     state;
    logic [W-1:0]   ptr;

    logic           release_now;
    logic [N-1:0]   pick_req;
    logic [N-1:0]   pick_onehot;
    logic [W-1:0]   pick_index;
    logic           pick_valid;
    logic [W-1:0]   next_ptr;

    // While owned, the current owner is masked so a release hands over to a
    // different requester; when idle every request competes.
    assign pick_req    = (state == ST_OWNED) ? (req & ~grant) : req;
    assign release_now = done | ~req[owner];
    assign next_ptr    = (pick_index == W'(N - 1)) ? '0 : (pick_index + W'(1));

    la_rrpick #(
        .N (N)
    ) u_pick (
        .req    (pick_req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .index  (pick_index),
        .valid  (pick_valid)
    );

    // Single FSM owning grant, busy, owner and ptr. In OWNED without a
    // release nothing is touched, so unknown values on non-granted request
    // bits cannot disturb the held grant.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state <= ST_OWNED;
                        grant <= pick_onehot;
                        busy  <= 1'b1;
                        owner <= pick_index;
                        ptr   <= next_ptr;
                    end
                end
                ST_OWNED: begin
                    if (release_now) begin
                        if (pick_valid) begin
                            grant <= pick_onehot;
                            busy  <= 1'b1;
                            owner <= pick_index;
                            ptr   <= next_ptr;
                        end else begin
                            state <= ST_IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_la_rrarbiter.sv
// ---------------------------------------------------------------------------
// tb_la_rrarbiter
// Purpose : directed self-checking bench for la_rrarbiter with N=4.
// ---------------------------------------------------------------------------
module tb_la_rrarbiter;

    logic       clk;
    logic       nreset;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner;

    int checks;
    int failures;

    la_rrarbiter #(
        .N    (4),
        .PROP ("DEFAULT")
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .busy   (busy),
        .owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; one rising edge later outputs are
    // sampled on the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        req    = 4'b1111;
        done   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (grant !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_grant got=%b exp=%b", grant, 4'b0000);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy got=%b exp=%b", busy, 1'b0);
        end
        checks++;
        if (owner !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_owner got=%0d exp=%0d", owner, 0);
        end
        nreset = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_grant got=%b/%0d/%b exp=0001/0/1", grant, owner, busy);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req  = 4'b1111;
        done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (grant !== exp_seq[i] || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL fair_%0d got=%b busy=%b exp=%b busy=1", i, grant, busy, exp_seq[i]);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_lock();
        logic [3:0] noise [4];
        noise = '{4'b0100, 4'b1101, 4'b0110, 4'b1111};
        // Owner 0, ptr 1: two handovers bring ownership to requester 2.
        req  = 4'b1111;
        done = 1'b1;
        step();
        step();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0100 || owner !== 2'd2) begin
            failures++;
            $display("[TB] FAIL lock_setup got=%b/%0d exp=0100/2", grant, owner);
        end
        for (int i = 0; i < 10; i++) begin
            req = noise[i % 4];
            step();
            checks++;
            if (grant !== 4'b0100) begin
                failures++;
                $display("[TB] FAIL lock_hold_%0d got=%b exp=%b", i, grant, 4'b0100);
            end
        end
        req = 4'bx1xx;
        step();
        step();
        checks++;
        if (grant !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lock_xreq got=%b/%0d/%b exp=0100/2/1", grant, owner, busy);
        end
        req  = 4'b1111;
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (grant !== 4'b1000 || owner !== 2'd3) begin
            failures++;
            $display("[TB] FAIL lock_release got=%b/%0d exp=1000/3", grant, owner);
        end
    endtask

    task automatic test_withdrawal();
        // Owner 3, ptr 0: two handovers reach owner 1 with ptr 2.
        req  = 4'b1111;
        done = 1'b1;
        step();
        step();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL wd_setup got=%b exp=%b", grant, 4'b0010);
        end
        req = 4'b0001;
        step();
        checks++;
        if (grant !== 4'b0001 || owner !== 2'd0) begin
            failures++;
            $display("[TB] FAIL wd_handover got=%b/%0d exp=0001/0", grant, owner);
        end
        // ptr is now 1, so requester 1 wins next even with all bits set.
        req  = 4'b1111;
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0010 || owner !== 2'd1) begin
            failures++;
            $display("[TB] FAIL wd_ptr got=%b/%0d exp=0010/1", grant, owner);
        end
        // Released owner is masked for the handover cycle only.
        req  = 4'b0010;
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || owner !== 2'd1) begin
            failures++;
            $display("[TB] FAIL wd_mask got=%b/%b/%0d exp=0000/0/1", grant, busy, owner);
        end
        step();
        checks++;
        if (grant !== 4'b0010 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wd_regrant got=%b/%b exp=0010/1", grant, busy);
        end
    endtask

    task automatic test_idle_return();
        // Owner 1, ptr 2: handover to 2, then to 3.
        req  = 4'b1100;
        done = 1'b1;
        step();
        req = 4'b1000;
        step();
        checks++;
        if (grant !== 4'b1000 || owner !== 2'd3) begin
            failures++;
            $display("[TB] FAIL idle_setup got=%b/%0d exp=1000/3", grant, owner);
        end
        step();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || owner !== 2'd3) begin
            failures++;
            $display("[TB] FAIL idle_enter got=%b/%b/%0d exp=0000/0/3", grant, busy, owner);
        end
        req  = 4'b0000;
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || owner !== 2'd3) begin
            failures++;
            $display("[TB] FAIL idle_done_ignored got=%b/%b/%0d exp=0000/0/3", grant, busy, owner);
        end
        req = 4'b1001;
        step();
        checks++;
        if (grant !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL idle_regrant got=%b/%0d/%b exp=0001/0/1", grant, owner, busy);
        end
    endtask

    task automatic test_reset_mid();
        // Owner 0 withdraws; requester 2 is the only one left.
        req = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL rmid_setup got=%b exp=%b", grant, 4'b0100);
        end
        #2 nreset = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
            failures++;
            $display("[TB] FAIL rmid_async got=%b/%b/%0d exp=0000/0/0", grant, busy, owner);
        end
        @(negedge clk);
        req    = 4'b0110;
        nreset = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0010 || owner !== 2'd1) begin
            failures++;
            $display("[TB] FAIL rmid_first got=%b/%0d exp=0010/1", grant, owner);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fairness();
        test_lock();
        test_withdrawal();
        test_idle_return();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
